// File: rtl/invaders_pkg.sv
// Shared grid geometry, march timing constants, FSM state type and pixel-pitch helpers
// for the alien formation sequencer.
package invaders_pkg;

  localparam int unsigned NUM_ROWS    = 5;
  localparam int unsigned NUM_COLS    = 10;
  localparam int unsigned ALIEN_W     = 30;
  localparam int unsigned ALIEN_H     = 20;
  localparam int unsigned SPACE_W     = 10;
  localparam int unsigned SPACE_H     = 10;
  localparam int unsigned SCREEN_W    = 640;

  localparam int unsigned START_COL   = 20;
  localparam int unsigned START_ROW   = 40;
  localparam int unsigned STEP_X      = 4;
  localparam int unsigned DROP_Y      = 10;
  localparam int unsigned LAND_ROW    = 400;
  localparam int unsigned BASE_PERIOD = 30;
  localparam int unsigned MIN_PERIOD  = 2;

  localparam int unsigned GRID_W = NUM_ROWS * NUM_COLS;
  localparam int unsigned COL_W  = $clog2(NUM_COLS);
  localparam int unsigned ROW_W  = $clog2(NUM_ROWS);
  localparam int unsigned CNT_W  = 6;
  localparam int unsigned EDGE_W = 11;
  localparam int unsigned FCNT_W = 5;
  localparam int unsigned X_W    = 10;
  localparam int unsigned Y_W    = 9;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCAN   = 2'd1,
    DECIDE = 2'd2
  } march_state_t;

  // Horizontal pixel offset of a grid column from the formation origin.
  function automatic logic [EDGE_W-1:0] pitch_x(input logic [COL_W-1:0] col);
    return EDGE_W'(col) * EDGE_W'(ALIEN_W + SPACE_W);
  endfunction

  // Vertical pixel offset of a grid row from the formation origin.
  function automatic logic [EDGE_W-1:0] pitch_y(input logic [ROW_W-1:0] row);
    return EDGE_W'(row) * EDGE_W'(ALIEN_H + SPACE_H);
  endfunction

endpackage

// File: rtl/alien_grid_scanner.sv
// Column-serial scan of the live-alien mask: accumulates leftmost/rightmost live column,
// lowest live row and (with ALIEN_SPEEDUP_EN) the live-alien popcount.
module alien_grid_scanner
  import invaders_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              active,
  input  logic [GRID_W-1:0] grid,
  output logic [COL_W-1:0]  leftmost,
  output logic [COL_W-1:0]  rightmost,
  output logic [ROW_W-1:0]  lowest,
  output logic              any_alive,
`ifdef ALIEN_SPEEDUP_EN
  output logic [CNT_W-1:0]  count,
`endif
  output logic              done_c
);

  logic [COL_W-1:0]    col_idx;
  logic [NUM_COLS-1:0] rows [NUM_ROWS];
  logic [NUM_ROWS-1:0] col_bits;
  logic [ROW_W-1:0]    col_low;
`ifdef ALIEN_SPEEDUP_EN
  logic [CNT_W-1:0]    col_cnt;
`endif

  // Slice out the current column; the grid is sampled live each cycle.
  always_comb begin
    col_bits = '0;
    col_low  = '0;
    for (int r = 0; r < NUM_ROWS; r++) begin
      rows[r]     = grid[r*NUM_COLS +: NUM_COLS];
      col_bits[r] = rows[r][col_idx];
      if (col_bits[r]) begin
        col_low = ROW_W'(r);
      end
    end
  end

`ifdef ALIEN_SPEEDUP_EN
  always_comb begin
    col_cnt = '0;
    for (int r = 0; r < NUM_ROWS; r++) begin
      col_cnt = col_cnt + CNT_W'(col_bits[r]);
    end
  end
`endif

  assign done_c = active && (col_idx == COL_W'(NUM_COLS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_idx   <= '0;
      leftmost  <= '0;
      rightmost <= '0;
      lowest    <= '0;
      any_alive <= 1'b0;
`ifdef ALIEN_SPEEDUP_EN
      count     <= '0;
`endif
    end else if (start) begin
      col_idx   <= '0;
      leftmost  <= '0;
      rightmost <= '0;
      lowest    <= '0;
      any_alive <= 1'b0;
`ifdef ALIEN_SPEEDUP_EN
      count     <= '0;
`endif
    end else if (active) begin
      col_idx <= col_idx + COL_W'(1);
      // Columns arrive in ascending order, so the first live one is leftmost.
      if (|col_bits) begin
        if (!any_alive) begin
          leftmost <= col_idx;
        end
        rightmost <= col_idx;
        any_alive <= 1'b1;
        if (col_low > lowest) begin
          lowest <= col_low;
        end
      end
`ifdef ALIEN_SPEEDUP_EN
      count <= count + col_cnt;
`endif
    end
  end

endmodule

// File: rtl/alien_march_ctrl.sv
// Per-frame alien formation march sequencer: scans the live grid, then steps or drops the origin.
// Optional macro ALIEN_SPEEDUP_EN: step period shrinks with the live-alien count.
module alien_march_ctrl
  import invaders_pkg::*;
(
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              FrameTick,
  input  logic              Restart,
  input  logic [GRID_W-1:0] Aliens_Grid,
  output logic [X_W-1:0]    AliensCol,
  output logic [Y_W-1:0]    AliensRow,
  output logic              DirRight,
  output logic              StepPulse,
  output logic              Landed,
  output logic              AllDead
);

  march_state_t      state, state_next;
  logic [FCNT_W-1:0] fcnt, fcnt_next;
  logic [FCNT_W-1:0] period_m1;
  logic [X_W-1:0]    col_next;
  logic [Y_W-1:0]    row_next;
  logic              dir_next, pulse_next, landed_next, dead_next;
  logic [EDGE_W-1:0] right_edge, left_edge, land_edge;

  logic              scan_start_c;
  logic              scan_done_c;
  logic [COL_W-1:0]  leftmost, rightmost;
  logic [ROW_W-1:0]  lowest;
  logic              any_alive;
`ifdef ALIEN_SPEEDUP_EN
  logic [CNT_W-1:0]  alive_cnt;
`endif

  assign scan_start_c = (state == IDLE) && FrameTick && !Restart;

  alien_grid_scanner u_scanner (
    .clk       (Clk),
    .rst_n     (Reset_n),
    .start     (scan_start_c),
    .active    (state == SCAN),
    .grid      (Aliens_Grid),
    .leftmost  (leftmost),
    .rightmost (rightmost),
    .lowest    (lowest),
    .any_alive (any_alive),
`ifdef ALIEN_SPEEDUP_EN
    .count     (alive_cnt),
`endif
    .done_c    (scan_done_c)
  );

  // Frames per step, minus one, as the terminal value of the frame counter.
`ifdef ALIEN_SPEEDUP_EN
  assign period_m1 = FCNT_W'(MIN_PERIOD - 1) + FCNT_W'(alive_cnt >> 1);
`else
  assign period_m1 = FCNT_W'(BASE_PERIOD - 1);
`endif

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next  = state;
    col_next    = AliensCol;
    row_next    = AliensRow;
    dir_next    = DirRight;
    pulse_next  = 1'b0;
    landed_next = Landed;
    dead_next   = AllDead;
    fcnt_next   = fcnt;
    right_edge  = EDGE_W'(AliensCol) + pitch_x(rightmost) + EDGE_W'(ALIEN_W + STEP_X);
    left_edge   = EDGE_W'(AliensCol) + pitch_x(leftmost);
    land_edge   = '0;

    case (state)
      IDLE: begin
        if (Restart) begin
          col_next    = X_W'(START_COL);
          row_next    = Y_W'(START_ROW);
          dir_next    = 1'b1;
          landed_next = 1'b0;
          dead_next   = 1'b0;
          fcnt_next   = '0;
        end else if (FrameTick) begin
          state_next = SCAN;
        end
      end

      SCAN: begin
        if (scan_done_c) begin
          state_next = DECIDE;
        end
      end

      DECIDE: begin
        state_next = IDLE;
        dead_next  = !any_alive;
        if (any_alive && !Landed) begin
          if (fcnt < period_m1) begin
            fcnt_next = fcnt + FCNT_W'(1);
          end else begin
            fcnt_next  = '0;
            pulse_next = 1'b1;
            // Hitting a screen edge turns the move into a drop and reverses direction.
            if (DirRight) begin
              if (right_edge > EDGE_W'(SCREEN_W)) begin
                row_next = AliensRow + Y_W'(DROP_Y);
                dir_next = 1'b0;
              end else begin
                col_next = AliensCol + X_W'(STEP_X);
              end
            end else begin
              if (left_edge < EDGE_W'(STEP_X)) begin
                row_next = AliensRow + Y_W'(DROP_Y);
                dir_next = 1'b1;
              end else begin
                col_next = AliensCol - X_W'(STEP_X);
              end
            end
          end
          land_edge = EDGE_W'(row_next) + pitch_y(lowest) + EDGE_W'(ALIEN_H);
          if (land_edge >= EDGE_W'(LAND_ROW)) begin
            landed_next = 1'b1;
          end
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      AliensCol <= X_W'(START_COL);
      AliensRow <= Y_W'(START_ROW);
      DirRight  <= 1'b1;
      StepPulse <= 1'b0;
      Landed    <= 1'b0;
      AllDead   <= 1'b0;
      fcnt      <= '0;
    end else begin
      AliensCol <= col_next;
      AliensRow <= row_next;
      DirRight  <= dir_next;
      StepPulse <= pulse_next;
      Landed    <= landed_next;
      AllDead   <= dead_next;
      fcnt      <= fcnt_next;
    end
  end

endmodule

// File: tb/tb_alien_march_ctrl.sv
// Self-checking bench for alien_march_ctrl: frame-level reference model, directed march
// scenarios and randomized grids (with mid-scan grid changes).
module tb_alien_march_ctrl;

  localparam int NR = 5;
  localparam int NC = 10;
`ifdef ALIEN_SPEEDUP_EN
  localparam int FULL_PERIOD = 27;
`else
  localparam int FULL_PERIOD = 30;
`endif
  localparam logic [49:0] G_FULL = {50{1'b1}};

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b1;
  logic        FrameTick = 1'b0;
  logic        Restart = 1'b0;
  logic [49:0] Aliens_Grid = '0;
  logic [9:0]  AliensCol;
  logic [8:0]  AliensRow;
  logic        DirRight, StepPulse, Landed, AllDead;

  int errors = 0;
  int checks = 0;

  int m_col, m_row, m_fcnt;
  bit m_dir, m_landed, m_dead;

  alien_march_ctrl dut (
    .Clk         (Clk),
    .Reset_n     (Reset_n),
    .FrameTick   (FrameTick),
    .Restart     (Restart),
    .Aliens_Grid (Aliens_Grid),
    .AliensCol   (AliensCol),
    .AliensRow   (AliensRow),
    .DirRight    (DirRight),
    .StepPulse   (StepPulse),
    .Landed      (Landed),
    .AllDead     (AllDead)
  );

  always #5 Clk = ~Clk;

  function automatic logic [49:0] col_mask(input int c);
    logic [49:0] m;
    m = '0;
    for (int r = 0; r < NR; r++) m[r*NC + c] = 1'b1;
    return m;
  endfunction

  task automatic model_reset();
    m_col = 20; m_row = 40; m_dir = 1; m_landed = 0; m_dead = 0; m_fcnt = 0;
  endtask

  // One frame of the game rules applied to the grid as the scan saw it.
  task automatic model_frame(input logic [49:0] g, output bit stepped);
    int left, right, low, cnt, period;
    left = NC; right = -1; low = 0; cnt = 0; stepped = 0;
    for (int r = 0; r < NR; r++)
      for (int c = 0; c < NC; c++)
        if (g[r*NC + c]) begin
          cnt++;
          if (c < left) left = c;
          if (c > right) right = c;
          if (r > low) low = r;
        end
    m_dead = (cnt == 0);
    if (m_dead || m_landed) return;
`ifdef ALIEN_SPEEDUP_EN
    period = 2 + cnt / 2;
`else
    period = 30;
`endif
    if (m_fcnt < period - 1) begin
      m_fcnt++;
    end else begin
      m_fcnt = 0;
      stepped = 1;
      if (m_dir) begin
        if (m_col + right * 40 + 30 + 4 > 640) begin m_row += 10; m_dir = 0; end
        else m_col += 4;
      end else begin
        if (m_col + left * 40 < 4) begin m_row += 10; m_dir = 1; end
        else m_col -= 4;
      end
    end
    if (m_row + low * 30 + 20 >= 400) m_landed = 1;
  endtask

  // Drives one frame starting at a negedge with the DUT idle; grid switches to g2 after edge sw.
  task automatic run_frame(input logic [49:0] g1, input logic [49:0] g2, input int sw,
                           output logic [22:0] obs, output logic early, output logic [22:0] exp);
    logic [49:0] eff;
    bit st;
    for (int r = 0; r < NR; r++)
      for (int c = 0; c < NC; c++)
        eff[r*NC + c] = (c < sw) ? g1[r*NC + c] : g2[r*NC + c];
    model_frame(eff, st);
    exp = {10'(m_col), 9'(m_row), m_dir, st, m_landed, m_dead};
    Aliens_Grid = g1;
    FrameTick = 1'b1;
    early = 1'b0;
    obs = '0;
    for (int j = 0; j < 12; j++) begin
      @(negedge Clk);
      if (j == 0) FrameTick = 1'b0;
      if (j == sw) Aliens_Grid = g2;
      if (j == 10) early = StepPulse;
      if (j == 11) obs = {AliensCol, AliensRow, DirRight, StepPulse, Landed, AllDead};
    end
  endtask

  task automatic do_restart();
    Restart = 1'b1;
    @(negedge Clk);
    Restart = 1'b0;
    @(negedge Clk);
    model_reset();
  endtask

  task automatic test_reset();
    #2 Reset_n = 1'b0;
    #1;
    checks++; if (AliensCol !== 10'd20) begin errors++; $display("FAIL reset_col: got %0d exp 20", AliensCol); end
    checks++; if (AliensRow !== 9'd40) begin errors++; $display("FAIL reset_row: got %0d exp 40", AliensRow); end
    checks++; if ({DirRight, StepPulse, Landed, AllDead} !== 4'b1000) begin
      errors++; $display("FAIL reset_flags: got %b exp 1000", {DirRight, StepPulse, Landed, AllDead});
    end
    @(negedge Clk);
    Reset_n = 1'b1;
    @(negedge Clk);
    model_reset();
  endtask

  task automatic test_first_step();
    logic [22:0] obs, exp; logic early;
    for (int i = 1; i <= FULL_PERIOD; i++) begin
      run_frame(G_FULL, G_FULL, 10, obs, early, exp);
      checks++; if (obs !== exp || early !== 1'b0) begin
        errors++; $display("FAIL first_step frame %0d: got %h/%b exp %h/0", i, obs, early, exp);
      end
      checks++; if (obs[2] !== (i == FULL_PERIOD)) begin
        errors++; $display("FAIL first_step_pulse frame %0d: got %b exp %b", i, obs[2], i == FULL_PERIOD);
      end
    end
    checks++; if (AliensCol !== 10'd24 || AliensRow !== 9'd40) begin
      errors++; $display("FAIL first_step_pos: got %0d/%0d exp 24/40", AliensCol, AliensRow);
    end
  endtask

  task automatic test_march_right();
    logic [22:0] obs, exp; logic early; int n;
    n = 0;
    while (m_col != 248 && n < 2500) begin
      run_frame(G_FULL, G_FULL, 10, obs, early, exp); n++;
      checks++; if (obs !== exp || early !== 1'b0) begin
        errors++; $display("FAIL march_right frame %0d: got %h exp %h", n, obs, exp);
      end
    end
    checks++; if (AliensCol !== 10'd248 || AliensRow !== 9'd40 || DirRight !== 1'b1) begin
      errors++; $display("FAIL right_edge_pos: got %0d/%0d/%b exp 248/40/1", AliensCol, AliensRow, DirRight);
    end
    for (int k = 0; k < 2; k++) begin
      n = 0;
      do begin
        run_frame(G_FULL, G_FULL, 10, obs, early, exp); n++;
        checks++; if (obs !== exp) begin
          errors++; $display("FAIL march_turn frame %0d: got %h exp %h", n, obs, exp);
        end
      end while (obs[2] !== 1'b1 && n < 40);
      if (k == 0) begin
        checks++; if (AliensCol !== 10'd248 || AliensRow !== 9'd50 || DirRight !== 1'b0) begin
          errors++; $display("FAIL right_drop: got %0d/%0d/%b exp 248/50/0", AliensCol, AliensRow, DirRight);
        end
      end else begin
        checks++; if (AliensCol !== 10'd244 || AliensRow !== 9'd50) begin
          errors++; $display("FAIL first_left_step: got %0d/%0d exp 244/50", AliensCol, AliensRow);
        end
      end
    end
  endtask

  task automatic test_left_edge();
    logic [22:0] obs, exp; logic early; int n;
    logic [49:0] g;
    g = col_mask(0);
    n = 0;
    while (m_col != 4 && n < 2500) begin
      run_frame(g, g, 10, obs, early, exp); n++;
      checks++; if (obs !== exp || early !== 1'b0) begin
        errors++; $display("FAIL march_left frame %0d: got %h exp %h", n, obs, exp);
      end
    end
    checks++; if (AliensCol !== 10'd4) begin errors++; $display("FAIL left_near: got %0d exp 4", AliensCol); end
    for (int k = 0; k < 2; k++) begin
      n = 0;
      do begin
        run_frame(g, g, 10, obs, early, exp); n++;
        checks++; if (obs !== exp) begin
          errors++; $display("FAIL left_turn frame %0d: got %h exp %h", n, obs, exp);
        end
      end while (obs[2] !== 1'b1 && n < 40);
    end
    checks++; if (AliensCol !== 10'd0 || AliensRow !== 9'd60 || DirRight !== 1'b1) begin
      errors++; $display("FAIL left_drop: got %0d/%0d/%b exp 0/60/1", AliensCol, AliensRow, DirRight);
    end
  endtask

  task automatic test_reset_mid_scan();
    logic [22:0] obs, exp; logic early;
    Aliens_Grid = G_FULL;
    FrameTick = 1'b1;
    @(negedge Clk);
    FrameTick = 1'b0;
    repeat (3) @(negedge Clk);
    Reset_n = 1'b0;
    #1;
    checks++; if ({AliensCol, AliensRow, DirRight, StepPulse} !== {10'd20, 9'd40, 1'b1, 1'b0}) begin
      errors++; $display("FAIL mid_scan_reset: got %0d/%0d/%b exp 20/40/1", AliensCol, AliensRow, DirRight);
    end
    @(negedge Clk);
    Reset_n = 1'b1;
    @(negedge Clk);
    model_reset();
    for (int i = 1; i <= FULL_PERIOD; i++) begin
      run_frame(G_FULL, G_FULL, 10, obs, early, exp);
      checks++; if (obs !== exp || early !== 1'b0) begin
        errors++; $display("FAIL after_reset frame %0d: got %h exp %h", i, obs, exp);
      end
    end
  endtask

  task automatic test_restart();
    logic [22:0] obs, exp; logic early;
    for (int i = 0; i < 3; i++) run_frame(G_FULL, G_FULL, 10, obs, early, exp);
    Restart = 1'b1;
    FrameTick = 1'b1;
    @(negedge Clk);
    Restart = 1'b0;
    FrameTick = 1'b0;
    @(negedge Clk);
    model_reset();
    checks++; if ({AliensCol, AliensRow, DirRight, Landed} !== {10'd20, 9'd40, 1'b1, 1'b0}) begin
      errors++; $display("FAIL restart_reload: got %0d/%0d/%b/%b exp 20/40/1/0", AliensCol, AliensRow, DirRight, Landed);
    end
    for (int i = 1; i <= FULL_PERIOD; i++) begin
      run_frame(G_FULL, G_FULL, 10, obs, early, exp);
      checks++; if (obs !== exp) begin
        errors++; $display("FAIL restart_period frame %0d: got %h exp %h", i, obs, exp);
      end
    end
  endtask

  task automatic test_all_dead();
    logic [22:0] obs, exp; logic early;
    for (int i = 0; i < 5; i++) begin
      run_frame('0, '0, 10, obs, early, exp);
      checks++; if (obs !== exp) begin
        errors++; $display("FAIL all_dead frame %0d: got %h exp %h", i, obs, exp);
      end
    end
    checks++; if (AllDead !== 1'b1 || StepPulse !== 1'b0) begin
      errors++; $display("FAIL all_dead_flag: got %b/%b exp 1/0", AllDead, StepPulse);
    end
    run_frame(G_FULL, G_FULL, 10, obs, early, exp);
    checks++; if (obs !== exp || AllDead !== 1'b0) begin
      errors++; $display("FAIL revive: got %h exp %h", obs, exp);
    end
  endtask

  task automatic test_random();
    logic [22:0] obs, exp; logic early;
    logic [63:0] r64;
    logic [49:0] g1, g2;
    int sw;
    for (int i = 0; i < 120; i++) begin
      r64 = {$urandom(), $urandom()}; g1 = r64[49:0];
      if ($urandom_range(0, 2) == 0) begin r64 = {$urandom(), $urandom()}; g1 &= r64[49:0]; end
      if ($urandom_range(0, 9) == 0) g1 = '0;
      g2 = g1;
      sw = 10;
      if ($urandom_range(0, 3) == 0) begin
        r64 = {$urandom(), $urandom()}; g2 = r64[49:0];
        sw = $urandom_range(0, 9);
      end
      run_frame(g1, g2, sw, obs, early, exp);
      checks++; if (obs !== exp || early !== 1'b0) begin
        errors++; $display("FAIL random frame %0d: got %h/%b exp %h/0", i, obs, early, exp);
      end
    end
  endtask

`ifdef ALIEN_SPEEDUP_EN
  task automatic test_speedup();
    logic [22:0] obs, exp; logic early;
    logic [49:0] g;
    int pulses;
    do_restart();
    g = '0;
    g[$urandom_range(0, 49)] = 1'b1;
    pulses = 0;
    for (int i = 1; i <= 6; i++) begin
      run_frame(g, g, 10, obs, early, exp);
      pulses += int'(obs[2]);
      checks++; if (obs !== exp || obs[2] !== (i % 2 == 0)) begin
        errors++; $display("FAIL speedup frame %0d: got %h exp %h", i, obs, exp);
      end
    end
    checks++; if (pulses != 3) begin errors++; $display("FAIL speedup_count: got %0d exp 3", pulses); end
  endtask

  task automatic test_landing();
    logic [22:0] obs, exp; logic early;
    logic [49:0] g;
    int n;
    do_restart();
    n = 0;
    while (!m_landed && n < 4000) begin
      g = '0;
      if (m_dir) g[49] = 1'b1; else g[40] = 1'b1;
      run_frame(g, g, 10, obs, early, exp); n++;
      checks++; if (obs !== exp) begin
        errors++; $display("FAIL landing frame %0d: got %h exp %h", n, obs, exp);
      end
    end
    checks++; if (Landed !== 1'b1 || AliensRow !== 9'd260) begin
      errors++; $display("FAIL landed: got %b/%0d exp 1/260", Landed, AliensRow);
    end
    for (int i = 0; i < 4; i++) begin
      run_frame(g, g, 10, obs, early, exp);
      checks++; if (obs !== exp || obs[2] !== 1'b0) begin
        errors++; $display("FAIL landed_frozen frame %0d: got %h exp %h", i, obs, exp);
      end
    end
    do_restart();
    checks++; if ({Landed, AliensCol, AliensRow} !== {1'b0, 10'd20, 9'd40}) begin
      errors++; $display("FAIL landed_restart: got %b/%0d/%0d exp 0/20/40", Landed, AliensCol, AliensRow);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_first_step();
    test_march_right();
    test_left_edge();
    test_reset_mid_scan();
    test_restart();
    test_all_dead();
    test_random();
`ifdef ALIEN_SPEEDUP_EN
    test_speedup();
    test_landing();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
